control_sequencer: RTL and testbench

- Hardwired Mini SRC control unit. Generates every control strobe of the 32-bit bus datapath, replacing hand-driven bench control.
- Runs the 3-step fetch (T0–T2), decodes IR, then runs a per-opcode execute sequence (T3–T7). Loops back to T0 or halts.
- Sits beside the datapath. Its only datapath inputs are IR and the CON flag.

---
 rtl/control_sequencer.sv | 204 ++++++++++++++++++++
 tb/tb_control_sequencer.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/control_sequencer.sv
// control_sequencer: hardwired control unit for the Mini SRC 32-bit bus datapath.
// Runs a 3-step fetch (T0-T2), decodes the opcode in IR, then a per-opcode
// execute sequence (T3-T7). It returns to T0, or goes to HALT on a halt
// opcode or on a stop request at an instruction boundary.
// Ports:
//   clk, reset (sync, active low)
//   ir      - IR value from datapath; opcode = ir[BITS-1 -: OPW]
//   con     - branch condition flag
//   stop    - halt request, honoured on the last step of an instruction
//   out_sel - one-hot bus driver select
//   in_sel  - register load enables
//   gr_sel  - {Gra,Grb,Grc}
//   alu_op  - one-hot ALU operation
//   read/write - memory strobes
//   run     - high while sequencing
//   state   - 0 RST, 1..8 T0..T7, 15 HALT
module control_sequencer #(
  parameter int BITS = 32,
  parameter int OPW  = 5
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [BITS-1:0] ir,
  input  logic            con,
  input  logic            stop,
  output logic [7:0]      out_sel,
  output logic [9:0]      in_sel,
  output logic [2:0]      gr_sel,
  output logic [12:0]     alu_op,
  output logic            read,
  output logic            write,
  output logic            run,
  output logic [3:0]      state
);
  // out_sel bit positions
  localparam int O_PC = 0, O_MDR = 1, O_RZ = 2, O_HILO = 3, O_INP = 4, O_C = 5, O_R = 6, O_BA = 7;
  // in_sel bit positions
  localparam int I_PC = 0, I_IR = 1, I_RY = 2, I_RZ = 3, I_MAR = 4, I_MDR = 5, I_HILO = 6,
                 I_OUT = 7, I_CON = 8, I_R = 9;
  // gr_sel bit positions
  localparam int G_C = 0, G_B = 1, G_A = 2;
  // alu_op bit positions
  localparam int A_ADD = 0, A_SUB = 1, A_MUL = 2, A_DIV = 3, A_SHR = 4, A_SHL = 5, A_ROR = 6,
                 A_ROL = 7, A_AND = 8, A_OR = 9, A_NEG = 10, A_NOT = 11, A_INC = 12;

  typedef enum logic [3:0] {
    S_RST = 4'd0, S_T0 = 4'd1, S_T1 = 4'd2, S_T2 = 4'd3, S_T3 = 4'd4,
    S_T4 = 4'd5, S_T5 = 4'd6, S_T6 = 4'd7, S_T7 = 4'd8, S_HALT = 4'd15
  } state_t;

  // Instruction classes sharing an execute sequence
  typedef enum logic [3:0] {
    C_NONE, C_ALU3, C_IMM, C_LDI, C_LD, C_ST, C_MD, C_UN, C_BR, C_JR, C_IN, C_OUT, C_HALT
  } cls_t;

  state_t           state_q, state_d, last_st;
  cls_t             cls;
  logic [12:0]      dec_op;
  logic [OPW-1:0]   opc;

  assign opc   = ir[BITS-1 -: OPW];
  assign state = state_q;

  // Opcode -> class and the ALU op used by that class
  always_comb begin
    cls    = C_NONE;
    dec_op = '0;
    case (opc)
      5'b00000: cls = C_LD;
      5'b00001: cls = C_LDI;
      5'b00010: cls = C_ST;
      5'b00011: begin cls = C_ALU3; dec_op[A_ADD] = 1'b1; end
      5'b00100: begin cls = C_ALU3; dec_op[A_SUB] = 1'b1; end
      5'b00101: begin cls = C_ALU3; dec_op[A_AND] = 1'b1; end
      5'b00110: begin cls = C_ALU3; dec_op[A_OR]  = 1'b1; end
      5'b00111: begin cls = C_ALU3; dec_op[A_SHR] = 1'b1; end
      5'b01000: begin cls = C_ALU3; dec_op[A_SHL] = 1'b1; end
      5'b01001: begin cls = C_ALU3; dec_op[A_ROR] = 1'b1; end
      5'b01010: begin cls = C_ALU3; dec_op[A_ROL] = 1'b1; end
      5'b01011: begin cls = C_IMM;  dec_op[A_ADD] = 1'b1; end
      5'b01100: begin cls = C_IMM;  dec_op[A_AND] = 1'b1; end
      5'b01101: begin cls = C_IMM;  dec_op[A_OR]  = 1'b1; end
      5'b01110: begin cls = C_MD;   dec_op[A_MUL] = 1'b1; end
      5'b01111: begin cls = C_MD;   dec_op[A_DIV] = 1'b1; end
      5'b10000: begin cls = C_UN;   dec_op[A_NEG] = 1'b1; end
      5'b10001: begin cls = C_UN;   dec_op[A_NOT] = 1'b1; end
      5'b10010: cls = C_BR;
      5'b10011: cls = C_JR;
      5'b10101: cls = C_IN;
      5'b10110: cls = C_OUT;
      5'b11010: cls = C_HALT;
      default:  cls = C_NONE;
    endcase
  end

  // Final execute step of each class
  always_comb begin
    case (cls)
      C_ALU3, C_IMM, C_LDI, C_MD: last_st = S_T5;
      C_LD, C_ST:                 last_st = S_T7;
      C_UN:                       last_st = S_T4;
      C_BR:                       last_st = S_T6;
      default:                    last_st = S_T3;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) state_q <= S_RST;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_RST: state_d = S_T0;
      S_T0:  state_d = S_T1;
      S_T1:  state_d = S_T2;
      // Opcode decode happens on the edge leaving T2
      S_T2: begin
        if (cls == C_HALT)      state_d = S_HALT;
        else if (cls == C_NONE) state_d = stop ? S_HALT : S_T0;
        else                    state_d = S_T3;
      end
      S_T3, S_T4, S_T5, S_T6, S_T7: begin
        if (state_q == last_st) state_d = stop ? S_HALT : S_T0;
        else                    state_d = state_t'(state_q + 4'd1);
      end
      S_HALT: state_d = S_HALT;
      default: state_d = S_RST;
    endcase
  end

  always_comb begin
    out_sel = '0;
    in_sel  = '0;
    gr_sel  = '0;
    alu_op  = '0;
    read    = 1'b0;
    write   = 1'b0;
    run     = (state_q != S_RST) && (state_q != S_HALT);
    case (state_q)
      S_T0: begin out_sel[O_PC] = 1'b1; in_sel[I_MAR] = 1'b1; in_sel[I_RZ] = 1'b1; alu_op[A_INC] = 1'b1; end
      S_T1: begin out_sel[O_RZ] = 1'b1; in_sel[I_PC] = 1'b1; in_sel[I_MDR] = 1'b1; read = 1'b1; end
      S_T2: begin out_sel[O_MDR] = 1'b1; in_sel[I_IR] = 1'b1; end
      S_T3, S_T4, S_T5, S_T6, S_T7: begin
        case (cls)
          C_ALU3, C_IMM: case (state_q)
            S_T3: begin gr_sel[G_B] = 1'b1; out_sel[O_R] = 1'b1; in_sel[I_RY] = 1'b1; end
            S_T4: begin
              if (cls == C_IMM) out_sel[O_C] = 1'b1;
              else begin gr_sel[G_C] = 1'b1; out_sel[O_R] = 1'b1; end
              alu_op = dec_op; in_sel[I_RZ] = 1'b1;
            end
            S_T5: begin out_sel[O_RZ] = 1'b1; gr_sel[G_A] = 1'b1; in_sel[I_R] = 1'b1; end
            default: ;
          endcase
          // ldi/ld/st share the effective-address computation in T3-T4
          C_LDI, C_LD, C_ST: case (state_q)
            S_T3: begin gr_sel[G_B] = 1'b1; out_sel[O_BA] = 1'b1; in_sel[I_RY] = 1'b1; end
            S_T4: begin out_sel[O_C] = 1'b1; alu_op[A_ADD] = 1'b1; in_sel[I_RZ] = 1'b1; end
            S_T5: begin
              out_sel[O_RZ] = 1'b1;
              if (cls == C_LDI) begin gr_sel[G_A] = 1'b1; in_sel[I_R] = 1'b1; end
              else in_sel[I_MAR] = 1'b1;
            end
            S_T6: begin
              if (cls == C_LD) begin read = 1'b1; in_sel[I_MDR] = 1'b1; end
              else if (cls == C_ST) begin gr_sel[G_A] = 1'b1; out_sel[O_R] = 1'b1; in_sel[I_MDR] = 1'b1; end
            end
            S_T7: begin
              if (cls == C_LD) begin out_sel[O_MDR] = 1'b1; gr_sel[G_A] = 1'b1; in_sel[I_R] = 1'b1; end
              else if (cls == C_ST) write = 1'b1;
            end
            default: ;
          endcase
          C_MD: case (state_q)
            S_T3: begin gr_sel[G_A] = 1'b1; out_sel[O_R] = 1'b1; in_sel[I_RY] = 1'b1; end
            S_T4: begin gr_sel[G_B] = 1'b1; out_sel[O_R] = 1'b1; alu_op = dec_op; in_sel[I_RZ] = 1'b1; end
            S_T5: in_sel[I_HILO] = 1'b1;
            default: ;
          endcase
          C_UN: case (state_q)
            S_T3: begin gr_sel[G_B] = 1'b1; out_sel[O_R] = 1'b1; alu_op = dec_op; in_sel[I_RZ] = 1'b1; end
            S_T4: begin out_sel[O_RZ] = 1'b1; gr_sel[G_A] = 1'b1; in_sel[I_R] = 1'b1; end
            default: ;
          endcase
          C_BR: case (state_q)
            S_T3: begin gr_sel[G_A] = 1'b1; out_sel[O_R] = 1'b1; in_sel[I_CON] = 1'b1; end
            S_T4: begin out_sel[O_PC] = 1'b1; in_sel[I_RY] = 1'b1; end
            S_T5: begin out_sel[O_C] = 1'b1; alu_op[A_ADD] = 1'b1; in_sel[I_RZ] = 1'b1; end
            // CON FF was loaded in T3, so con is settled here
            S_T6: if (con) begin out_sel[O_RZ] = 1'b1; in_sel[I_PC] = 1'b1; end
            default: ;
          endcase
          C_JR:  if (state_q == S_T3) begin gr_sel[G_A] = 1'b1; out_sel[O_R] = 1'b1; in_sel[I_PC] = 1'b1; end
          C_IN:  if (state_q == S_T3) begin out_sel[O_INP] = 1'b1; gr_sel[G_A] = 1'b1; in_sel[I_R] = 1'b1; end
          C_OUT: if (state_q == S_T3) begin gr_sel[G_A] = 1'b1; out_sel[O_R] = 1'b1; in_sel[I_OUT] = 1'b1; end
          default: ;
        endcase
      end
      default: ;
    endcase
  end
endmodule

// File: tb/tb_control_sequencer.sv
// Directed bench for control_sequencer: hand-computed strobe vectors per step.
module tb_control_sequencer;
  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] ir;
  logic        con, stop;
  logic [7:0]  out_sel;
  logic [9:0]  in_sel;
  logic [2:0]  gr_sel;
  logic [12:0] alu_op;
  logic        read, write, run;
  logic [3:0]  state;
  int          total = 0, bad = 0;
  logic        inv_en = 1'b0;

  localparam logic [7:0] O_PC = 8'h01, O_MDR = 8'h02, O_RZ = 8'h04, O_INP = 8'h10,
                         O_C = 8'h20, O_R = 8'h40, O_BA = 8'h80;
  localparam logic [9:0] I_PC = 10'h001, I_IR = 10'h002, I_RY = 10'h004, I_RZ = 10'h008,
                         I_MAR = 10'h010, I_MDR = 10'h020, I_HILO = 10'h040, I_OUT = 10'h080,
                         I_CON = 10'h100, I_R = 10'h200;
  localparam logic [2:0] G_C = 3'd1, G_B = 3'd2, G_A = 3'd4;
  localparam logic [12:0] A_ADD = 13'h0001, A_MUL = 13'h0004, A_OR = 13'h0200,
                          A_NOT = 13'h0800, A_INC = 13'h1000;

  control_sequencer #(.BITS(32), .OPW(5)) dut (
    .clk(clk), .reset(reset), .ir(ir), .con(con), .stop(stop),
    .out_sel(out_sel), .in_sel(in_sel), .gr_sel(gr_sel), .alu_op(alu_op),
    .read(read), .write(write), .run(run), .state(state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %h want %h", tag, got, want);
    end
  endtask

  // Expected vector {state,out,in,gr,alu,read,write,run}
  task automatic expect_st(input string tag, input logic [3:0] st, input logic [7:0] o,
                           input logic [9:0] i, input logic [2:0] g, input logic [12:0] a,
                           input logic rd = 1'b0, input logic wr = 1'b0);
    logic rn;
    rn = (st != 4'd0) && (st != 4'd15);
    chk(tag, {23'd0, state, out_sel, in_sel, gr_sel, alu_op, read, write, run},
             {23'd0, st, o, i, g, a, rd, wr, rn});
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // Checks T0..T2 starting with T0 visible, ends one edge after T2
  task automatic fetch(input string tag);
    expect_st({tag, "_t0"}, 4'd1, O_PC, I_MAR | I_RZ, 3'd0, A_INC);
    tick();
    expect_st({tag, "_t1"}, 4'd2, O_RZ, I_PC | I_MDR, 3'd0, 13'd0, 1'b1);
    tick();
    expect_st({tag, "_t2"}, 4'd3, O_MDR, I_IR, 3'd0, 13'd0);
    tick();
  endtask

  always @(negedge clk) begin
    if (inv_en)
      chk("invariants", {60'd0, $onehot0(out_sel), $onehot0(alu_op), $onehot0(gr_sel), !(read && write)},
          64'hF);
  end

  initial begin
    reset = 1'b0; ir = 32'd0; con = 1'b0; stop = 1'b0;
    repeat (3) tick();
    inv_en = 1'b1;
    expect_st("reset", 4'd0, 8'd0, 10'd0, 3'd0, 13'd0);
    reset = 1'b1;
    tick();

    // add
    ir = {5'b00011, 27'd0};
    fetch("add");
    expect_st("add_t3", 4'd4, O_R, I_RY, G_B, 13'd0);  tick();
    expect_st("add_t4", 4'd5, O_R, I_RZ, G_C, A_ADD);  tick();
    expect_st("add_t5", 4'd6, O_RZ, I_R, G_A, 13'd0);  tick();

    // addi: T4 uses Cout
    ir = {5'b01011, 27'd0};
    fetch("addi");
    expect_st("addi_t3", 4'd4, O_R, I_RY, G_B, 13'd0); tick();
    expect_st("addi_t4", 4'd5, O_C, I_RZ, 3'd0, A_ADD); tick();
    expect_st("addi_t5", 4'd6, O_RZ, I_R, G_A, 13'd0); tick();

    // br taken and not taken
    for (int k = 0; k < 2; k++) begin
      ir = {5'b10010, 27'd0};
      con = (k == 0);
      fetch("br");
      expect_st("br_t3", 4'd4, O_R, I_CON, G_A, 13'd0); tick();
      expect_st("br_t4", 4'd5, O_PC, I_RY, 3'd0, 13'd0); tick();
      expect_st("br_t5", 4'd6, O_C, I_RZ, 3'd0, A_ADD); tick();
      if (k == 0) expect_st("br_t6_taken", 4'd7, O_RZ, I_PC, 3'd0, 13'd0);
      else        expect_st("br_t6_not", 4'd7, 8'd0, 10'd0, 3'd0, 13'd0);
      tick();
    end
    con = 1'b0;

    // st
    ir = {5'b00010, 27'd0};
    fetch("st");
    expect_st("st_t3", 4'd4, O_BA, I_RY, G_B, 13'd0);   tick();
    expect_st("st_t4", 4'd5, O_C, I_RZ, 3'd0, A_ADD);   tick();
    expect_st("st_t5", 4'd6, O_RZ, I_MAR, 3'd0, 13'd0); tick();
    expect_st("st_t6", 4'd7, O_R, I_MDR, G_A, 13'd0);   tick();
    expect_st("st_t7", 4'd8, 8'd0, 10'd0, 3'd0, 13'd0, 1'b0, 1'b1); tick();

    // mul
    ir = {5'b01110, 27'd0};
    fetch("mul");
    expect_st("mul_t3", 4'd4, O_R, I_RY, G_A, 13'd0);    tick();
    expect_st("mul_t4", 4'd5, O_R, I_RZ, G_B, A_MUL);    tick();
    expect_st("mul_t5", 4'd6, 8'd0, I_HILO, 3'd0, 13'd0); tick();

    // not
    ir = {5'b10001, 27'd0};
    fetch("not");
    expect_st("not_t3", 4'd4, O_R, I_RZ, G_B, A_NOT); tick();
    expect_st("not_t4", 4'd5, O_RZ, I_R, G_A, 13'd0); tick();

    // jr, in, out: single execute step
    ir = {5'b10011, 27'd0};
    fetch("jr");
    expect_st("jr_t3", 4'd4, O_R, I_PC, G_A, 13'd0); tick();
    ir = {5'b10101, 27'd0};
    fetch("in");
    expect_st("in_t3", 4'd4, O_INP, I_R, G_A, 13'd0); tick();
    ir = {5'b10110, 27'd0};
    fetch("out");
    expect_st("out_t3", 4'd4, O_R, I_OUT, G_A, 13'd0); tick();

    // nop and undefined skip execute
    ir = {5'b11001, 27'd0};
    fetch("nop");
    ir = {5'b10100, 27'd0};
    fetch("undef");

    // halt held for 20 cycles
    ir = {5'b11010, 27'd0};
    fetch("halt");
    for (int k = 0; k < 20; k++) begin
      expect_st("halt_hold", 4'd15, 8'd0, 10'd0, 3'd0, 13'd0);
      tick();
    end

    // reset, then or with stop on the last step
    reset = 1'b0; tick();
    expect_st("reset2", 4'd0, 8'd0, 10'd0, 3'd0, 13'd0);
    reset = 1'b1; tick();
    ir = {5'b00110, 27'd0};
    fetch("or");
    expect_st("or_t3", 4'd4, O_R, I_RY, G_B, 13'd0); tick();
    expect_st("or_t4", 4'd5, O_R, I_RZ, G_C, A_OR);  tick();
    expect_st("or_t5", 4'd6, O_RZ, I_R, G_A, 13'd0);
    stop = 1'b1; tick();
    expect_st("or_stop", 4'd15, 8'd0, 10'd0, 3'd0, 13'd0);
    stop = 1'b0;

    // ld interrupted by reset in T6
    reset = 1'b0; tick();
    reset = 1'b1; tick();
    ir = {5'b00000, 27'd0};
    fetch("ld");
    expect_st("ld_t3", 4'd4, O_BA, I_RY, G_B, 13'd0);   tick();
    expect_st("ld_t4", 4'd5, O_C, I_RZ, 3'd0, A_ADD);   tick();
    expect_st("ld_t5", 4'd6, O_RZ, I_MAR, 3'd0, 13'd0); tick();
    expect_st("ld_t6", 4'd7, 8'd0, I_MDR, 3'd0, 13'd0, 1'b1);
    reset = 1'b0; tick();
    expect_st("ld_abort", 4'd0, 8'd0, 10'd0, 3'd0, 13'd0);
    reset = 1'b1; tick();
    expect_st("restart_t0", 4'd1, O_PC, I_MAR | I_RZ, 3'd0, A_INC);

    inv_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
